// File: rtl/cp_redund_pkg.sv
// Shared types and default constants for the A/B redundancy scheduler.
package cp_redund_pkg;

  localparam int unsigned FRAME_TIMEOUT_DEF  = 3125;
  localparam int unsigned MISS_LIMIT_DEF     = 3;
  localparam int unsigned RECOVER_FRAMES_DEF = 64;
  localparam int unsigned HOLDOFF_DEF        = 400000;
  localparam int unsigned STATE_W            = 3;

  typedef enum logic [STATE_W-1:0] {
    ACT_A = 3'd0,
    ACT_B = 3'd1,
    SW_AB = 3'd2,
    SW_BA = 3'd3,
    NONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/cp_link_health.sv
// Per-link health tracker: frame watchdog, saturating miss/good counters
// and a registered health flag with hysteresis.
module cp_link_health
  import cp_redund_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT  = FRAME_TIMEOUT_DEF,
  parameter int unsigned MISS_LIMIT     = MISS_LIMIT_DEF,
  parameter int unsigned RECOVER_FRAMES = RECOVER_FRAMES_DEF
) (
  input  logic clk_20M,
  input  logic reset_n,
  input  logic frame,
  input  logic crcerr,
  output logic health
);

  localparam int unsigned WD_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int unsigned MC_W = $clog2(MISS_LIMIT + 1);
  localparam int unsigned GC_W = $clog2(RECOVER_FRAMES + 1);

  logic [WD_W-1:0] wd;
  logic [MC_W-1:0] miss_cnt;
  logic [GC_W-1:0] good_cnt;
  logic            expired;
  logic            miss;
  logic            good;

  // A frame in the same cycle as watchdog expiry suppresses the timeout miss.
  always_comb begin
    expired = (wd == WD_W'(FRAME_TIMEOUT - 1));
    miss    = frame ? crcerr : expired;
    good    = frame & ~crcerr;
  end

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      wd       <= '0;
      miss_cnt <= '0;
      good_cnt <= '0;
      health   <= 1'b1;
    end else begin
      if (frame || expired) wd <= '0;
      else                  wd <= wd + WD_W'(1);

      if (miss) begin
        good_cnt <= '0;
        if (miss_cnt != MC_W'(MISS_LIMIT)) miss_cnt <= miss_cnt + MC_W'(1);
        if (miss_cnt >= MC_W'(MISS_LIMIT - 1)) health <= 1'b0;
      end else if (good) begin
        miss_cnt <= '0;
        if (good_cnt != GC_W'(RECOVER_FRAMES)) good_cnt <= good_cnt + GC_W'(1);
        if (good_cnt >= GC_W'(RECOVER_FRAMES - 1)) health <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp_redund_sched.sv
// Redundancy scheduler: health-driven A/B selection with frame-aligned
// handover and a holdoff on operator-forced switches.
module cp_redund_sched
  import cp_redund_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT  = FRAME_TIMEOUT_DEF,
  parameter int unsigned MISS_LIMIT     = MISS_LIMIT_DEF,
  parameter int unsigned RECOVER_FRAMES = RECOVER_FRAMES_DEF,
  parameter int unsigned HOLDOFF        = HOLDOFF_DEF
) (
  input  logic               clk_20M,
  input  logic               reset_n,
  input  logic               i_frame_A,
  input  logic               i_frame_B,
  input  logic               i_crcerr_A,
  input  logic               i_crcerr_B,
  input  logic               i_force_A,
  input  logic               i_force_B,
  output logic               o_sel_B,
  output logic               o_switch_pulse,
  output logic               o_health_A,
  output logic               o_health_B,
  output logic               o_both_fail,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned HO_W  = $clog2(HOLDOFF + 1);
  localparam int unsigned SWT_W = $clog2(FRAME_TIMEOUT + 1);

  sched_state_t     state, state_nx;
  logic             sel_nx, pulse_nx;
  logic [HO_W-1:0]  holdoff;
  logic [SWT_W-1:0] sw_tmr;
  logic             force_a, force_b, good_a, good_b, ho_done, sw_late, in_sw;

  cp_link_health #(
    .FRAME_TIMEOUT (FRAME_TIMEOUT),
    .MISS_LIMIT    (MISS_LIMIT),
    .RECOVER_FRAMES(RECOVER_FRAMES)
  ) u_health_a (
    .clk_20M(clk_20M), .reset_n(reset_n),
    .frame(i_frame_A), .crcerr(i_crcerr_A), .health(o_health_A)
  );

  cp_link_health #(
    .FRAME_TIMEOUT (FRAME_TIMEOUT),
    .MISS_LIMIT    (MISS_LIMIT),
    .RECOVER_FRAMES(RECOVER_FRAMES)
  ) u_health_b (
    .clk_20M(clk_20M), .reset_n(reset_n),
    .frame(i_frame_B), .crcerr(i_crcerr_B), .health(o_health_B)
  );

  always_comb begin
    force_a  = i_force_A & ~i_force_B;
    force_b  = i_force_B & ~i_force_A;
    good_a   = i_frame_A & ~i_crcerr_A;
    good_b   = i_frame_B & ~i_crcerr_B;
    ho_done  = (holdoff == '0);
    sw_late  = (sw_tmr == SWT_W'(FRAME_TIMEOUT - 1));
    in_sw    = (state == SW_AB) || (state == SW_BA);
    state_nx = state;
    sel_nx   = o_sel_B;
    pulse_nx = 1'b0;
    case (state)
      ACT_A: begin
        if (!o_health_A && !o_health_B)                            state_nx = NONE;
        else if (o_health_B && (!o_health_A || (force_b && ho_done))) state_nx = SW_AB;
      end
      ACT_B: begin
        if (!o_health_A && !o_health_B)                            state_nx = NONE;
        else if (o_health_A && (!o_health_B || (force_a && ho_done))) state_nx = SW_BA;
      end
      SW_AB: begin
        if (!o_health_B) state_nx = ACT_A;
        else if (good_b) begin
          state_nx = ACT_B;
          sel_nx   = 1'b1;
          pulse_nx = 1'b1;
        end else if (sw_late) state_nx = ACT_A;
      end
      SW_BA: begin
        if (!o_health_A) state_nx = ACT_B;
        else if (good_a) begin
          state_nx = ACT_A;
          sel_nx   = 1'b0;
          pulse_nx = 1'b1;
        end else if (sw_late) state_nx = ACT_B;
      end
      NONE: begin
        // Recovering link already selected: resume without a handover.
        if (o_health_A)      state_nx = o_sel_B ? SW_BA : ACT_A;
        else if (o_health_B) state_nx = o_sel_B ? ACT_B : SW_AB;
      end
      default: state_nx = ACT_A;
    endcase
  end

  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      state          <= ACT_A;
      o_sel_B        <= 1'b0;
      o_switch_pulse <= 1'b0;
      o_both_fail    <= 1'b0;
      holdoff        <= '0;
      sw_tmr         <= '0;
    end else begin
      state          <= state_nx;
      o_sel_B        <= sel_nx;
      o_switch_pulse <= pulse_nx;
      o_both_fail    <= (state_nx == NONE);
      if (pulse_nx)            holdoff <= HO_W'(HOLDOFF);
      else if (!ho_done)       holdoff <= holdoff - HO_W'(1);
      if (in_sw && state_nx == state) sw_tmr <= sw_tmr + SWT_W'(1);
      else                            sw_tmr <= '0;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_cp_redund_sched.sv
// Randomized bench for cp_redund_sched against a cycle-level behavioural model.
module tb_cp_redund_sched;

  localparam int unsigned FT = 40;
  localparam int unsigned ML = 3;
  localparam int unsigned RF = 4;
  localparam int unsigned HO = 300;
  localparam logic [7:0] RST_VEC = 8'b000_0_0_1_1_0;

  logic       clk_20M = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_frame_A = 1'b0, i_frame_B = 1'b0;
  logic       i_crcerr_A = 1'b0, i_crcerr_B = 1'b0;
  logic       i_force_A = 1'b0, i_force_B = 1'b0;
  logic       o_sel_B, o_switch_pulse, o_health_A, o_health_B, o_both_fail;
  logic [2:0] o_state;

  cp_redund_sched #(
    .FRAME_TIMEOUT (FT),
    .MISS_LIMIT    (ML),
    .RECOVER_FRAMES(RF),
    .HOLDOFF       (HO)
  ) dut (
    .clk_20M(clk_20M), .reset_n(reset_n),
    .i_frame_A(i_frame_A), .i_frame_B(i_frame_B),
    .i_crcerr_A(i_crcerr_A), .i_crcerr_B(i_crcerr_B),
    .i_force_A(i_force_A), .i_force_B(i_force_B),
    .o_sel_B(o_sel_B), .o_switch_pulse(o_switch_pulse),
    .o_health_A(o_health_A), .o_health_B(o_health_B),
    .o_both_fail(o_both_fail), .o_state(o_state)
  );

  always #25 clk_20M = ~clk_20M;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: link 0 = A, 1 = B; states use the published codes.
  int     m_wd[2], m_mc[2], m_gc[2];
  bit     m_h[2];
  int     m_st = 0, m_hold = 0;
  bit     m_sel = 0, m_pulse = 0, m_fail = 0;
  longint cyc = 0, sw_enter = 0;

  always @(posedge clk_20M) begin
    bit fr[2], er[2], gd[2];
    bit fa, fb, want;
    int nst, tgt, ev;
    cyc++;
    fr[0] = i_frame_A;  fr[1] = i_frame_B;
    er[0] = i_crcerr_A; er[1] = i_crcerr_B;
    if (!reset_n) begin
      for (int l = 0; l < 2; l++) begin
        m_wd[l] = 0; m_mc[l] = 0; m_gc[l] = 0; m_h[l] = 1'b1;
      end
      m_st = 0; m_hold = 0; m_sel = 1'b0; m_pulse = 1'b0; m_fail = 1'b0;
    end else begin
      fa = i_force_A && !i_force_B;
      fb = i_force_B && !i_force_A;
      for (int l = 0; l < 2; l++) gd[l] = fr[l] && !er[l];
      nst = m_st;
      m_pulse = 1'b0;
      case (m_st)
        0, 1: begin
          tgt  = 1 - m_st;
          want = (tgt == 1) ? fb : fa;
          if (!m_h[0] && !m_h[1]) nst = 4;
          else if (m_h[tgt] && (!m_h[m_st] || (want && m_hold == 0))) nst = (tgt == 1) ? 2 : 3;
        end
        2, 3: begin
          tgt = (m_st == 2) ? 1 : 0;
          if (!m_h[tgt]) nst = 1 - tgt;
          else if (gd[tgt]) begin
            nst = tgt; m_sel = (tgt == 1); m_pulse = 1'b1;
          end else if (cyc - sw_enter >= FT) nst = 1 - tgt;
        end
        default: begin
          if (m_h[0])      nst = m_sel ? 3 : 0;
          else if (m_h[1]) nst = m_sel ? 1 : 2;
        end
      endcase
      if (m_pulse) m_hold = HO;
      else if (m_hold > 0) m_hold--;
      if (nst != m_st && (nst == 2 || nst == 3)) sw_enter = cyc;
      m_st   = nst;
      m_fail = (nst == 4);
      for (int l = 0; l < 2; l++) begin
        ev = 0;
        if (fr[l]) begin
          m_wd[l] = 0;
          ev = er[l] ? -1 : 1;
        end else if (m_wd[l] == FT - 1) begin
          m_wd[l] = 0;
          ev = -1;
        end else m_wd[l]++;
        if (ev < 0) begin
          m_gc[l] = 0;
          m_mc[l] = (m_mc[l] + 1 > ML) ? ML : m_mc[l] + 1;
          if (m_mc[l] >= ML) m_h[l] = 1'b0;
        end else if (ev > 0) begin
          m_mc[l] = 0;
          m_gc[l] = (m_gc[l] + 1 > RF) ? RF : m_gc[l] + 1;
          if (m_gc[l] >= RF) m_h[l] = 1'b1;
        end
      end
    end
  end

  function automatic logic [7:0] dut_vec();
    return {o_state, o_sel_B, o_switch_pulse, o_health_A, o_health_B, o_both_fail};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {3'(m_st), m_sel, m_pulse, m_h[0], m_h[1], m_fail};
  endfunction

  int nxt[2] = '{0, 0};
  int pulses;

  // Period 0 = silent link; err is percent of frames with a checksum error.
  task automatic run_phase(input int pa, input int pb, input int ea, input int eb,
                           input bit fa, input bit fb, input int len, input bit rst);
    int  per[2], err[2];
    bit  f[2], e[2];
    per[0] = pa; per[1] = pb; err[0] = ea; err[1] = eb;
    pulses = 0;
    i_force_A = fa;
    i_force_B = fb;
    for (int c = 0; c < len; c++) begin
      @(negedge clk_20M);
      check("outs", dut_vec(), exp_vec());
      if (rst && c == 1) check("mid_reset", dut_vec(), RST_VEC);
      pulses += int'(o_switch_pulse);
      reset_n = !(rst && c == 0);
      for (int l = 0; l < 2; l++) begin
        f[l] = 1'b0;
        if (per[l] != 0) begin
          if (nxt[l] == 0) begin
            f[l] = 1'b1;
            nxt[l] = per[l] + int'($urandom_range(0, 2));
          end else nxt[l]--;
        end
        e[l] = f[l] ? ($urandom_range(0, 99) < err[l]) : 1'($urandom_range(0, 1));
      end
      i_frame_A = f[0]; i_crcerr_A = e[0];
      i_frame_B = f[1]; i_crcerr_B = e[1];
    end
  endtask

  initial begin
    int pr[5];
    int er[5];
    pr = '{0, 12, 25, 33, 45};
    er = '{0, 0, 5, 40, 100};
    repeat (2) @(negedge clk_20M);
    check("reset_outs", dut_vec(), RST_VEC);
    reset_n = 1'b1;

    run_phase(30, 30, 0, 0, 0, 0, 600, 0);
    check("healthy_no_pulse", pulses, 0);
    check("healthy_sel", o_sel_B, 1'b0);
    run_phase(0, 30, 0, 0, 0, 0, 600, 0);
    check("fail_a_sel", o_sel_B, 1'b1);
    check("fail_a_pulses", pulses, 1);
    run_phase(30, 30, 0, 0, 1, 0, 800, 0);
    check("force_a_back", o_sel_B, 1'b0);
    run_phase(30, 30, 0, 0, 0, 1, 100, 0);
    check("force_b_sel", o_sel_B, 1'b1);
    run_phase(30, 30, 0, 0, 1, 0, 150, 0);
    check("holdoff_blocks", o_sel_B, 1'b1);
    run_phase(30, 30, 0, 0, 1, 0, 400, 0);
    check("holdoff_expired", o_sel_B, 1'b0);
    run_phase(30, 30, 0, 0, 1, 1, 400, 0);
    check("both_force_none", o_sel_B, 1'b0);
    run_phase(0, 0, 0, 0, 0, 0, 400, 0);
    check("silent_both_fail", o_both_fail, 1'b1);
    check("silent_state", o_state, 3'd4);
    run_phase(0, 30, 0, 0, 0, 0, 400, 0);
    check("recover_b_state", o_state, 3'd1);
    check("recover_b_sel", o_sel_B, 1'b1);
    run_phase(30, 30, 0, 100, 0, 0, 400, 0);
    check("crc_b_back_a", o_sel_B, 1'b0);
    run_phase(30, 30, 0, 0, 0, 1, 20, 1);

    for (int p = 0; p < 30; p++) begin
      run_phase(pr[$urandom_range(0, 4)], pr[$urandom_range(0, 4)],
                er[$urandom_range(0, 4)], er[$urandom_range(0, 4)],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(150, 700)), ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
